// File: rtl/logphy_pkg.sv
// Shared logphy types and constants for the mainband transmit path.
// Flits are carried as 64 packed bytes, byte 0 in the least significant position.
package logphy_pkg;

    localparam int unsigned FLIT_BYTES      = 64;
    localparam int unsigned MB_LANES        = 16;
    localparam int unsigned UI_PER_CHUNK    = 8;
    localparam int unsigned CHUNKS_PER_FLIT = 4;
    localparam int unsigned VALID_HI_UI     = 4;

    localparam int unsigned UI_W    = $clog2(UI_PER_CHUNK);
    localparam int unsigned CHUNK_W = $clog2(CHUNKS_PER_FLIT);
    localparam int unsigned LANE_W  = $clog2(MB_LANES);

    typedef logic [FLIT_BYTES-1:0][7:0] flit_t;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        SEND,
        POSTAMBLE
    } mb_tx_state_e;

    // Lane i carries bit `ui` of byte (chunk*MB_LANES + i).
    function automatic logic [MB_LANES-1:0] lane_slice(
        input flit_t              f,
        input logic [CHUNK_W-1:0] chunk,
        input logic [UI_W-1:0]    ui
    );
        logic [MB_LANES-1:0] s;
        for (int unsigned i = 0; i < MB_LANES; i++) begin
            s[i] = f[{chunk, LANE_W'(i)}][ui];
        end
        return s;
    endfunction

endpackage

// File: rtl/mb_tx_flit_fifo.sv
// Flit-wide synchronous FIFO; exposes the head entry and the entry behind it
// so the serializer can pre-load the next flit on the cycle it pops.
module mb_tx_flit_fifo
    import logphy_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  flit_t                    push_data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output flit_t                    head_o,
    output flit_t                    head_next_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    flit_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_nxt;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rd_nxt      = rd_q + PTR_W'(1);
    assign head_o      = mem_q[rd_q];
    assign head_next_o = mem_q[rd_nxt];

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + PTR_W'(1);
        if (do_pop)  rd_d = rd_nxt;
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/mb_tx_serializer.sv
// Mainband transmit serializer: buffers flits and drives them onto 16 lanes as
// 4 chunks of 8 UI with valid framing and a forwarded-clock enable.
module mb_tx_serializer
    import logphy_pkg::*;
#(
    parameter int unsigned flit_buffer_size = 4,
    parameter int unsigned PRE_UI           = 4,
    parameter int unsigned POST_UI          = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [7:0]          data_i [FLIT_BYTES-1:0],
    output logic                ready_o,
    output logic                valid_oPin,
    output logic [MB_LANES-1:0] dataPins_o,
    output logic                periph_clk_en_o,
    output logic                busy_o
);

    localparam int unsigned CNT_W    = $clog2(flit_buffer_size) + 1;
    localparam int unsigned AMB_MAX  = (PRE_UI > POST_UI) ? PRE_UI : POST_UI;
    localparam int unsigned AMB_W    = $clog2(AMB_MAX + 1);
    localparam logic [UI_W-1:0]    UI_LAST    = UI_W'(UI_PER_CHUNK - 1);
    localparam logic [CHUNK_W-1:0] CHUNK_LAST = CHUNK_W'(CHUNKS_PER_FLIT - 1);

    mb_tx_state_e         state_q, state_d;
    logic [UI_W-1:0]      ui_q, ui_d;
    logic [CHUNK_W-1:0]   chunk_q, chunk_d;
    logic [AMB_W-1:0]     amb_q, amb_d;
    logic                 valid_q, valid_d;
    logic [MB_LANES-1:0]  pins_q, pins_d;
    logic                 clk_en_q, clk_en_d;

    flit_t                in_flit, head, head_next, src;
    logic                 full, empty, pop;
    logic [CNT_W-1:0]     count;

    always_comb begin
        for (int unsigned k = 0; k < FLIT_BYTES; k++) begin
            in_flit[k] = data_i[k];
        end
    end

    assign ready_o = !full;
    assign busy_o  = (state_q != IDLE) || !empty;

    mb_tx_flit_fifo #(
        .DEPTH (flit_buffer_size)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (valid_i),
        .push_data_i (in_flit),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .head_o      (head),
        .head_next_o (head_next)
    );

    always_comb begin
        state_d = state_q;
        ui_d    = ui_q;
        chunk_d = chunk_q;
        amb_d   = amb_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = PREAMBLE;
                    amb_d   = '0;
                end
            end
            PREAMBLE: begin
                if (amb_q == AMB_W'(PRE_UI - 1)) begin
                    state_d = SEND;
                    ui_d    = '0;
                    chunk_d = '0;
                end else begin
                    amb_d = amb_q + AMB_W'(1);
                end
            end
            SEND: begin
                ui_d = ui_q + UI_W'(1);
                if (ui_q == UI_LAST) begin
                    chunk_d = chunk_q + CHUNK_W'(1);
                    // Last UI of the flit: counters wrap to c=0,u=0 for a back-to-back flit.
                    if (chunk_q == CHUNK_LAST) begin
                        pop = 1'b1;
                        if (count <= CNT_W'(1)) begin
                            state_d = POSTAMBLE;
                            amb_d   = '0;
                        end
                    end
                end
            end
            POSTAMBLE: begin
                if (!empty) begin
                    state_d = SEND;
                    ui_d    = '0;
                    chunk_d = '0;
                end else if (amb_q == AMB_W'(POST_UI - 1)) begin
                    state_d = IDLE;
                end else begin
                    amb_d = amb_q + AMB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pins are loaded from next-state values; on a pop the next flit is the entry behind the head.
    always_comb begin
        src      = pop ? head_next : head;
        pins_d   = '0;
        valid_d  = 1'b0;
        clk_en_d = (state_d != IDLE);
        if (state_d == SEND) begin
            pins_d  = lane_slice(src, chunk_d, ui_d);
            valid_d = (ui_d < UI_W'(VALID_HI_UI));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ui_q     <= '0;
            chunk_q  <= '0;
            amb_q    <= '0;
            valid_q  <= 1'b0;
            pins_q   <= '0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ui_q     <= ui_d;
            chunk_q  <= chunk_d;
            amb_q    <= amb_d;
            valid_q  <= valid_d;
            pins_q   <= pins_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign valid_oPin      = valid_q;
    assign dataPins_o      = pins_q;
    assign periph_clk_en_o = clk_en_q;

endmodule

// File: tb/tb_mb_tx_serializer.sv
// Bench for mb_tx_serializer: a lane-level receiver model rebuilds flits from the
// pins and compares them in order with the flits the bench pushed.
module tb_mb_tx_serializer;
    import logphy_pkg::*;

    localparam int DEPTH = 4;
    localparam int PRE   = 4;
    localparam int POST  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  data_i [FLIT_BYTES-1:0];
    logic        ready_o, valid_oPin, periph_clk_en_o, busy_o;
    logic [15:0] dataPins_o;

    always #5 clk = ~clk;

    mb_tx_serializer #(
        .flit_buffer_size (DEPTH),
        .PRE_UI           (PRE),
        .POST_UI          (POST)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .data_i          (data_i),
        .ready_o         (ready_o),
        .valid_oPin      (valid_oPin),
        .dataPins_o      (dataPins_o),
        .periph_clk_en_o (periph_clk_en_o),
        .busy_o          (busy_o)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    en_rise  = 0;
    int    en_fall  = 0;
    int    en_rises = 0;
    logic  prev_en  = 1'b0;
    int    rx_count = 0;
    flit_t exp_q [$];
    int    start_q [$];

    bit          in_flit = 0;
    int          k_ui    = 0;
    flit_t       rx_f;
    logic [5:0]  bidx;
    logic [2:0]  bbit;
    logic [15:0] last_pins [32];
    logic        last_valid [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic check_flit(input string name, input flit_t act, input flit_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Receiver model: a flit is 32 UI starting at the first UI with valid high.
    always @(negedge clk) begin
        cyc++;
        if (reset !== 1'b1) begin
            in_flit = 0;
        end else begin
            if (periph_clk_en_o && !prev_en) begin en_rise = cyc; en_rises++; end
            if (!periph_clk_en_o && prev_en) en_fall = cyc;
            if (!in_flit && valid_oPin === 1'b1) begin
                in_flit = 1;
                k_ui    = 0;
                start_q.push_back(cyc);
            end
            if (in_flit) begin
                check("ui_valid", valid_oPin, ((k_ui % 8) < 4) ? 1 : 0);
                check("ui_clk_en", periph_clk_en_o, 1);
                last_pins[k_ui]  = dataPins_o;
                last_valid[k_ui] = valid_oPin;
                for (int i = 0; i < 16; i++) begin
                    bidx = 6'(16 * (k_ui / 8) + i);
                    bbit = 3'(k_ui % 8);
                    rx_f[bidx][bbit] = dataPins_o[i];
                end
                k_ui++;
                if (k_ui == 32) begin
                    in_flit = 0;
                    rx_count++;
                    check("flit_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) check_flit("flit_data", rx_f, exp_q.pop_front());
                end
            end else begin
                check("idle_pins", dataPins_o, 0);
            end
        end
        prev_en = periph_clk_en_o;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Called just after a negedge; leaves valid_i low one cycle after acceptance.
    task automatic push_flit(input flit_t f, input int max_wait, output int acc_cyc);
        int w;
        w = 0;
        for (int k = 0; k < FLIT_BYTES; k++) data_i[k] = f[k];
        valid_i = 1'b1;
        while (!ready_o && w < max_wait) begin
            tick();
            w++;
        end
        check("push_accepted", ready_o, 1);
        acc_cyc = -1;
        if (ready_o) begin
            exp_q.push_back(f);
            acc_cyc = cyc;
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int bound);
        int w;
        w = 0;
        while (start_q.size() < n && w < bound) begin tick(); w++; end
        check("flit_start_seen", (start_q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        int w;
        w = 0;
        while ((busy_o || periph_clk_en_o) && w < bound) begin tick(); w++; end
        check("reach_idle", {busy_o, periph_clk_en_o}, 0);
    endtask

    function automatic flit_t ascii_flit();
        flit_t f;
        for (int k = 0; k < FLIT_BYTES; k++) f[k] = 8'(8'h41 + (k % 26));
        f[0] = 8'hFF;
        f[8] = 8'hFE;
        return f;
    endfunction

    function automatic flit_t rand_flit();
        flit_t f;
        for (int k = 0; k < FLIT_BYTES; k++) f[k] = 8'($urandom);
        return f;
    endfunction

    typedef struct {
        string name;
        int    ui;
        int    lane;   // -1 selects the valid lane
        logic  exp;
    } pin_vec_t;

    pin_vec_t vt [14];

    initial begin
        int acc, acc5, s, rx_base;
        vt[0]  = '{"c0_lane0_u0",  0,  0, 1'b1};
        vt[1]  = '{"c0_lane0_u3",  3,  0, 1'b1};
        vt[2]  = '{"c0_lane0_u7",  7,  0, 1'b1};
        vt[3]  = '{"c0_lane8_u0",  0,  8, 1'b0};
        vt[4]  = '{"c0_lane8_u1",  1,  8, 1'b1};
        vt[5]  = '{"c0_lane8_u7",  7,  8, 1'b1};
        vt[6]  = '{"c0_lane1_u0",  0,  1, 1'b0};
        vt[7]  = '{"c0_lane1_u1",  1,  1, 1'b1};
        vt[8]  = '{"c3_lane15_u2", 26, 15, 1'b1};
        vt[9]  = '{"c3_lane15_u0", 24, 15, 1'b0};
        vt[10] = '{"valid_c0_u3",  3, -1, 1'b1};
        vt[11] = '{"valid_c0_u4",  4, -1, 1'b0};
        vt[12] = '{"valid_c3_u7",  31, -1, 1'b0};
        vt[13] = '{"valid_c3_u0",  24, -1, 1'b1};
        for (int k = 0; k < FLIT_BYTES; k++) data_i[k] = 8'h00;

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_oPin, 0);
        check("rst_pins", dataPins_o, 0);
        check("rst_clk_en", periph_clk_en_o, 0);
        check("rst_busy", busy_o, 0);
        reset = 1'b1;
        tick();

        // Single flit: latency, lane mapping, framing, clock-enable span
        start_q.delete();
        en_rises = 0;
        push_flit(ascii_flit(), 5, acc);
        check("lat_clk_en_low", periph_clk_en_o, 0);
        wait_starts(1, 50);
        check("lat_clk_en_rise", en_rise - acc, 2);
        check("lat_first_data", start_q[0] - en_rise, PRE);
        wait_idle(100);
        for (int v = 0; v < 14; v++) begin
            if (vt[v].lane < 0) check(vt[v].name, last_valid[vt[v].ui], vt[v].exp);
            else                check(vt[v].name, last_pins[vt[v].ui][vt[v].lane], vt[v].exp);
        end
        check("single_clk_en_span", en_fall - en_rise, PRE + 32 + POST);
        check("single_one_burst", en_rises, 1);

        // Two flits back to back
        start_q.delete();
        en_rises = 0;
        push_flit(rand_flit(), 5, acc);
        push_flit(rand_flit(), 5, s);
        check("b2b_push_consecutive", s - acc, 1);
        wait_starts(2, 120);
        wait_idle(200);
        check("b2b_contiguous", start_q[1] - start_q[0], 32);
        check("b2b_one_burst", en_rises, 1);
        check("b2b_clk_en_span", en_fall - en_rise, PRE + 64 + POST);

        // Overfill: fifth flit waits for the first pop
        start_q.delete();
        for (int n = 0; n < 4; n++) push_flit(rand_flit(), 5, acc);
        check("full_ready_low", ready_o, 0);
        check("full_busy", busy_o, 1);
        push_flit(rand_flit(), 200, acc5);
        check("full_accept_after_pop", acc5 - start_q[0], 32);
        wait_starts(5, 400);
        check("full_five_contiguous", start_q[4] - start_q[0], 128);
        wait_idle(400);

        // Push during postamble cycle 2: no preamble, clock enable held
        start_q.delete();
        en_rises = 0;
        push_flit(rand_flit(), 5, acc);
        wait_starts(1, 50);
        s = start_q[0];
        while (cyc < s + 33) tick();
        check("post_clk_en_held", periph_clk_en_o, 1);
        check("post_no_data", valid_oPin, 0);
        push_flit(rand_flit(), 5, acc);
        wait_starts(2, 50);
        check("post_resume", start_q[1] - start_q[0], 35);
        wait_idle(200);
        check("post_one_burst", en_rises, 1);
        check("post_clk_en_span", en_fall - en_rise, PRE + 32 + 3 + 32 + POST);

        // Reset at chunk 2, UI 3 aborts the flit
        start_q.delete();
        push_flit(rand_flit(), 5, acc);
        wait_starts(1, 50);
        s = start_q[0];
        while (cyc < s + 19) tick();
        reset = 1'b0;
        tick();
        check("mid_rst_pins", dataPins_o, 0);
        check("mid_rst_valid", valid_oPin, 0);
        check("mid_rst_clk_en", periph_clk_en_o, 0);
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_busy", busy_o, 0);
        reset = 1'b1;
        exp_q.delete();
        tick();
        start_q.delete();
        push_flit(ascii_flit(), 5, acc);
        wait_starts(1, 50);
        check("after_rst_first_data", start_q[0] - en_rise, PRE);
        wait_idle(100);

        // Random traffic against the receiver model
        rx_base = rx_count;
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 40)) tick();
            push_flit(rand_flit(), 200, acc);
        end
        wait_idle(2000);
        check("rand_flit_count", rx_count - rx_base, 16);
        check("rand_all_received", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
